// File: rtl/coproc_alu_sequencer.sv
// Avalon-MM sequencer for one coprocessor ALU operation: reset pulse, start pulse
// with latched opcode, then a bounded wait for done with cycle measurement.
//
// state | meaning
// IDLE  | no operation in progress, waiting for go or soft_reset
// RST   | ALU held in reset for RESET_CYCLES clocks
// STRT  | single-cycle start pulse to the ALU
// WAIT  | waiting for alu_done, bounded by TIMEOUT_CYCLES
module coproc_alu_sequencer #(
    parameter int unsigned OPW            = 4,
    parameter int unsigned RESET_CYCLES   = 4,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [1:0]      address,
    input  logic            chipselect,
    input  logic            write_n,
    input  logic [31:0]     writedata,
    output logic [31:0]     readdata,
    output logic            alu_reset,
    output logic            alu_start,
    output logic [OPW-1:0]  alu_opcode,
    input  logic            alu_done,
    output logic            irq
);

    localparam int RCW = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
    localparam logic [RCW-1:0] RST_LOAD = RCW'(RESET_CYCLES - 1);
    localparam logic [31:0]    TMO_LOAD = 32'(TIMEOUT_CYCLES - 1);
    localparam logic [31:0]    TMO_FULL = 32'(TIMEOUT_CYCLES);

    localparam logic [1:0] A_CTRL   = 2'd0;
    localparam logic [1:0] A_OPCODE = 2'd1;
    localparam logic [1:0] A_STATUS = 2'd2;
    localparam logic [1:0] A_CYCLES = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RST  = 2'd1,
        S_STRT = 2'd2,
        S_WAIT = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic              op_pending_q, op_pending_d;
    logic [RCW-1:0]    rst_cnt_q, rst_cnt_d;
    logic [31:0]       tmo_cnt_q, tmo_cnt_d;
    logic [31:0]       cycles_q, cycles_d;
    logic              done_q, done_d;
    logic              timeout_q, timeout_d;
    logic              aborted_q, aborted_d;
    logic              overrun_q, overrun_d;
    logic              ien_q, ien_d;
    logic [OPW-1:0]    opcode_q, opcode_d;
    logic [OPW-1:0]    alu_opcode_q, alu_opcode_d;
    logic              alu_reset_q, alu_reset_d;
    logic              alu_start_q, alu_start_d;
    logic              irq_q, irq_d;

    logic              wr_en;
    logic              ctrl_wr;
    logic              go;
    logic              soft_rst;
    logic              clr_flags;
    logic              busy;
    logic [31:0]       status;
    logic              unused_wd;

    assign wr_en     = chipselect & ~write_n;
    assign ctrl_wr   = wr_en & (address == A_CTRL);
    assign go        = ctrl_wr & writedata[0];
    assign soft_rst  = ctrl_wr & writedata[1];
    assign clr_flags = ctrl_wr & writedata[2];
    assign busy      = (state_q != S_IDLE);
    assign unused_wd = ^writedata[31:4];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            op_pending_q <= 1'b0;
            rst_cnt_q    <= '0;
            tmo_cnt_q    <= '0;
            cycles_q     <= '0;
            done_q       <= 1'b0;
            timeout_q    <= 1'b0;
            aborted_q    <= 1'b0;
            overrun_q    <= 1'b0;
            ien_q        <= 1'b0;
            opcode_q     <= '0;
            alu_opcode_q <= '0;
            alu_reset_q  <= 1'b1;
            alu_start_q  <= 1'b0;
            irq_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            op_pending_q <= op_pending_d;
            rst_cnt_q    <= rst_cnt_d;
            tmo_cnt_q    <= tmo_cnt_d;
            cycles_q     <= cycles_d;
            done_q       <= done_d;
            timeout_q    <= timeout_d;
            aborted_q    <= aborted_d;
            overrun_q    <= overrun_d;
            ien_q        <= ien_d;
            opcode_q     <= opcode_d;
            alu_opcode_q <= alu_opcode_d;
            alu_reset_q  <= alu_reset_d;
            alu_start_q  <= alu_start_d;
            irq_q        <= irq_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        op_pending_d = op_pending_q;
        rst_cnt_d    = rst_cnt_q;
        tmo_cnt_d    = tmo_cnt_q;
        cycles_d     = cycles_q;
        done_d       = done_q;
        timeout_d    = timeout_q;
        aborted_d    = aborted_q;
        overrun_d    = overrun_q;
        ien_d        = ien_q;
        opcode_d     = opcode_q;
        alu_opcode_d = alu_opcode_q;

        if (wr_en && (address == A_OPCODE)) begin
            opcode_d = writedata[OPW-1:0];
        end
        if (ctrl_wr) begin
            ien_d = writedata[3];
        end
        // Clears first so that any event in the same cycle still sets its flag.
        if (clr_flags) begin
            done_d    = 1'b0;
            timeout_d = 1'b0;
            aborted_d = 1'b0;
            overrun_d = 1'b0;
        end
        if (go && busy) begin
            overrun_d = 1'b1;
        end

        unique case (state_q)
            S_IDLE: begin
                if (soft_rst) begin
                    state_d      = S_RST;
                    op_pending_d = 1'b0;
                    rst_cnt_d    = RST_LOAD;
                end else if (go) begin
                    done_d       = 1'b0;
                    timeout_d    = 1'b0;
                    aborted_d    = 1'b0;
                    cycles_d     = '0;
                    alu_opcode_d = opcode_q;
                    state_d      = S_RST;
                    op_pending_d = 1'b1;
                    rst_cnt_d    = RST_LOAD;
                end
            end
            S_RST: begin
                if (rst_cnt_q == '0) begin
                    state_d = op_pending_q ? S_STRT : S_IDLE;
                end else begin
                    rst_cnt_d = rst_cnt_q - RCW'(1);
                end
            end
            S_STRT: begin
                state_d   = S_WAIT;
                tmo_cnt_d = TMO_LOAD;
            end
            S_WAIT: begin
                // Elapsed WAIT cycles, including this one, is TIMEOUT - remaining.
                if (alu_done) begin
                    state_d  = S_IDLE;
                    done_d   = 1'b1;
                    cycles_d = TMO_FULL - tmo_cnt_q;
                end else if (tmo_cnt_q == '0) begin
                    state_d   = S_IDLE;
                    timeout_d = 1'b1;
                    cycles_d  = TMO_FULL;
                end else begin
                    tmo_cnt_d = tmo_cnt_q - 32'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (soft_rst && busy) begin
            state_d      = S_RST;
            op_pending_d = 1'b0;
            aborted_d    = 1'b1;
            rst_cnt_d    = RST_LOAD;
            tmo_cnt_d    = '0;
        end
    end

    always_comb begin
        alu_reset_d = (state_d == S_RST);
        alu_start_d = (state_d == S_STRT);
        irq_d       = ien_q & (done_q | timeout_q | aborted_q);
        status      = {22'd0, state_q, 2'b00, ien_q, overrun_q, aborted_q,
                       timeout_q, done_q, busy};
        readdata    = '0;
        unique case (address)
            A_CTRL:   readdata = '0;
            A_OPCODE: readdata = 32'(opcode_q);
            A_STATUS: readdata = status;
            A_CYCLES: readdata = cycles_q;
            default:  readdata = '0;
        endcase
    end

    assign alu_reset  = alu_reset_q;
    assign alu_start  = alu_start_q;
    assign alu_opcode = alu_opcode_q;
    assign irq        = irq_q;

endmodule

// File: doc/coproc_alu_sequencer.md
# coproc_alu_sequencer

Avalon-MM-controlled sequencer that runs one ALU operation of the zoom coprocessor per software command. It replaces bare PIO-driven reset/start with a hardware sequence: hold the ALU in reset for a programmed pulse, issue a single-cycle start with a latched opcode, then wait for done under a timeout. It reports busy, done, timeout and abort status, the measured cycle count, and an interrupt to the HPS.

## Interface
- `OPW`, 4: opcode width driven to the ALU.
- `RESET_CYCLES`, 4: ALU reset pulse length in clocks; ≥1.
- `TIMEOUT_CYCLES`, 1024: maximum WAIT cycles before a timeout; ≥2, <2^32.

- `clk` in 1: single clock.
- `reset` in 1: asynchronous, active-high.
- `address` in 2: register select.
- `chipselect` in 1: slave select.
- `write_n` in 1: active-low write strobe.
- `writedata` in 32: write data.
- `readdata` out 32: read data; combinational, zero wait states.
- `alu_reset` out 1: ALU reset, active-high, registered.
- `alu_start` out 1: one-cycle start pulse, registered.
- `alu_opcode` out OPW: opcode, held stable from STRT through WAIT.
- `alu_done` in 1: ALU completion level or pulse; sampled only in WAIT.
- `irq` out 1: level interrupt.

## Operation
- A write occurs on a clock edge when `chipselect` is 1 and `write_n` is 0.
- Register map:
  - 0 CTRL: write-only.
    - bit0 go.
    - bit1 soft_reset.
    - bit2 clear_flags.
    - bit3 ien; stored, and reads back at STATUS bit5.
  - 1 OPCODE: R/W, bits[OPW-1:0]; upper bits read 0.
  - 2 STATUS: read-only.
    - bit0 busy (state ≠ IDLE).
    - bit1 done.
    - bit2 timeout.
    - bit3 aborted.
    - bit4 overrun.
    - bit5 ien.
    - bits[9:8] state encoding: IDLE=0, RST=1, STRT=2, WAIT=3.
  - 3 CYCLES: read-only, 32 bits.
- Reads of CTRL return 0.
- State machine:
  - IDLE, on go: clear done, timeout, aborted and CYCLES; latch OPCODE into `alu_opcode`; go to RST with `op_pending`=1.
  - IDLE, on soft_reset without go: go to RST with `op_pending`=0.
  - RST: `alu_reset`=1 for exactly RESET_CYCLES cycles. Then go to STRT if `op_pending`, otherwise IDLE.
  - STRT: `alu_start`=1 for one cycle, then WAIT.
  - WAIT, `alu_done`=1: go to IDLE; set done; CYCLES = WAIT cycles elapsed, including the done cycle (minimum 1).
  - WAIT, no done on the TIMEOUT_CYCLES-th cycle: go to IDLE; set timeout; CYCLES = TIMEOUT_CYCLES.
- Boundary rules:
  - Timeout and `alu_done` in the same cycle: done wins; timeout stays 0.
  - go written while busy: ignored; sets overrun (sticky).
  - soft_reset written while busy: aborts. Go to RST with `op_pending`=0, set aborted, clear the WAIT counter.
  - soft_reset and go in the same write: soft_reset wins. While busy this is also an overrun.
  - clear_flags: clears done, timeout, aborted and overrun. It applies in the same write as go; the go-side clears are then identical.
  - Flags are sticky until clear_flags or an accepted go.
  - OPCODE writes while busy update the register but not `alu_opcode`.
- `irq` = ien & (done | timeout | aborted). Registered; it updates one cycle after the flag.

## Timing
- Reset values:
  - state IDLE.
  - `alu_reset`=1, holding the ALU in reset during controller reset. It deasserts at the first clock edge after `reset` falls.
  - `alu_start`=0.
  - `alu_opcode`=0.
  - OPCODE=0, CYCLES=0, all flags 0, ien=0, `irq`=0.
- `readdata` reflects the current register value combinationally. The flag set on edge N is readable in the cycle after edge N.
- go accepted on edge N:
  - `alu_reset`=1 for cycles N+1 .. N+RESET_CYCLES.
  - `alu_start`=1 in cycle N+RESET_CYCLES+1.
  - WAIT begins at cycle N+RESET_CYCLES+2.
- `alu_done` sampled in WAIT cycle k (k=1 first): IDLE and done=1 after that edge, CYCLES=k.
- `alu_done` asserted in IDLE, RST or STRT has no effect.
- Asynchronous `reset` mid-operation: immediately forces the reset values above. `alu_start` is never glitched high.

## Test plan
- Basic op (RESET_CYCLES=4): OPCODE=0x5, go; `alu_done` in WAIT cycle 3.
  - Required: `alu_reset` high 4 cycles, then `alu_start` 1 cycle with `alu_opcode`=5.
  - STATUS=0x002, CYCLES=3.
- Timeout (TIMEOUT_CYCLES=16): go, `alu_done` never asserted.
  - Required: after 16 WAIT cycles STATUS bit2=1, bit1=0, CYCLES=16, busy=0.
- Done on the 16th WAIT cycle: done=1, timeout=0, CYCLES=16.
- Overrun and abort: go, then go during WAIT, then soft_reset during WAIT.
  - Required: overrun=1; `alu_reset` pulses 4 cycles; no second `alu_start`; aborted=1; state ends IDLE.
- Interrupt: ien=1, complete an op → `irq`=1 one cycle after done. Write clear_flags → `irq`=0 the cycle after.
- Reset mid-WAIT: assert `reset`.
  - Required: `alu_reset`=1 and `alu_start`=0 immediately; all STATUS fields 0 after release.
  - `alu_reset` drops at the next edge.
